// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter:
// state encoding, requester IDs and the block geometry constants.
package mem_arbiter_pkg;

  localparam int DMEM_BLOCK_ADDR_SIZE = 28;
  localparam int DBLOCK_SIZE_BITS     = 128;

  localparam logic ARB_ID_I = 1'b0;
  localparam logic ARB_ID_D = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache-controller ports and the memory port around mem_arbiter.
// slave = the arbiter's view; master = the caches plus memory model driving it.
interface mem_arbiter_if #(
  parameter int BADDR_W = mem_arbiter_pkg::DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_W = mem_arbiter_pkg::DBLOCK_SIZE_BITS
);
  // Handshake: requests are levels held until the matching ready/done pulse;
  // ready/done are single-cycle pulses, seen only by the granted requester.
  logic               icRen;
  logic [BADDR_W-1:0] icBlockAddr;
  logic               icReadReady;
  logic [BLOCK_W-1:0] icDout;

  logic               dcRen;
  logic               dcWen;
  logic [BADDR_W-1:0] dcBlockAddr;
  logic [BLOCK_W-1:0] dcDin;
  logic               dcReadReady;
  logic               dcWriteDone;
  logic [BLOCK_W-1:0] dcDout;

  logic               memRen;
  logic               memWen;
  logic [BADDR_W-1:0] memBlockAddr;
  logic [BLOCK_W-1:0] memDin;
  logic               memReadReady;
  logic               memWriteDone;
  logic [BLOCK_W-1:0] memDout;

  modport slave (
    input  icRen, icBlockAddr, dcRen, dcWen, dcBlockAddr, dcDin,
           memReadReady, memWriteDone, memDout,
    output icReadReady, icDout, dcReadReady, dcWriteDone, dcDout,
           memRen, memWen, memBlockAddr, memDin
  );

  modport master (
    output icRen, icBlockAddr, dcRen, dcWen, dcBlockAddr, dcDin,
           memReadReady, memWriteDone, memDout,
    input  icReadReady, icDout, dcReadReady, dcWriteDone, dcDout,
           memRen, memWen, memBlockAddr, memDin
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select between icache and dcache requests.
// prio_id names the requester that wins when both are asking.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic prio_id,
  output logic win_id
);

  always_comb begin
    win_id = ARB_ID_I;
    if (req_i && req_d) begin
      win_id = prio_id;
    end else if (req_d) begin
      win_id = ARB_ID_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single block-wide memory port between icache and dcache miss controllers.
// MEM_ARB_ROUND_ROBIN_EN: alternate priority on contention; otherwise dcache always wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BADDR_W = DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_W = DBLOCK_SIZE_BITS
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output arb_state_e    dbg_state
);

  arb_state_e         state_q, state_d;
  logic               mem_ren_q, mem_ren_d;
  logic               mem_wen_q, mem_wen_d;
  logic               op_wr_q, op_wr_d;
  logic [BADDR_W-1:0] addr_q, addr_d;
  logic [BLOCK_W-1:0] din_q, din_d;

  logic req_i, req_d;
  logic prio_id, win_id;
  logic ic_done, dc_rd_done, dc_wr_done;

  assign req_i = bus.icRen;
  assign req_d = bus.dcRen | bus.dcWen;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // The requester that did not win last time gets priority on contention.
  assign prio_id = ~last_q;
`else
  assign prio_id = ARB_ID_D;
`endif

  arb_pick u_pick (
    .req_i   (req_i),
    .req_d   (req_d),
    .prio_id (prio_id),
    .win_id  (win_id)
  );

  // Completion is qualified by owner and by latched operation, so a pulse of
  // the wrong type never reaches a requester.
  assign ic_done    = (state_q == ARB_GRANT_I) && bus.memReadReady;
  assign dc_rd_done = (state_q == ARB_GRANT_D) && !op_wr_q && bus.memReadReady;
  assign dc_wr_done = (state_q == ARB_GRANT_D) &&  op_wr_q && bus.memWriteDone;

  always_comb begin
    state_d   = state_q;
    mem_ren_d = 1'b0;
    mem_wen_d = 1'b0;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    din_d     = din_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (req_i || req_d) begin
          if (win_id == ARB_ID_D) begin
            state_d   = ARB_GRANT_D;
            addr_d    = bus.dcBlockAddr;
            din_d     = bus.dcDin;
            op_wr_d   = bus.dcWen;
            mem_wen_d = bus.dcWen;
            mem_ren_d = ~bus.dcWen;
          end else begin
            state_d   = ARB_GRANT_I;
            addr_d    = bus.icBlockAddr;
            din_d     = '0;
            op_wr_d   = 1'b0;
            mem_ren_d = 1'b1;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d = win_id;
`endif
        end
      end
      ARB_GRANT_I: begin
        if (ic_done) begin
          state_d = ARB_RELEASE;
        end else if (!req_i) begin
          state_d = ARB_IDLE;
        end else begin
          mem_ren_d = 1'b1;
        end
      end
      ARB_GRANT_D: begin
        if (dc_rd_done || dc_wr_done) begin
          state_d = ARB_RELEASE;
        end else if (!req_d) begin
          state_d = ARB_IDLE;
        end else begin
          mem_ren_d = ~op_wr_q;
          mem_wen_d = op_wr_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q    <= ARB_ID_I;
`endif
    end else begin
      state_q   <= state_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.memRen       = mem_ren_q;
  assign bus.memWen       = mem_wen_q;
  assign bus.memBlockAddr = addr_q;
  assign bus.memDin       = din_q;
  assign bus.icReadReady  = ic_done;
  assign bus.dcReadReady  = dc_rd_done;
  assign bus.dcWriteDone  = dc_wr_done;
  assign bus.icDout       = bus.memDout;
  assign bus.dcDout       = bus.memDout;
  assign dbg_state        = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single block-wide main-memory port between the instruction-cache and data-cache miss controllers. Each cache controller presents block-granular read/write requests exactly as it would to a private memory. The arbiter grants one requester at a time, latches its block address and write data, drives the memory strobes, and routes the completion handshake back to the granted requester only. It sits between the two cache controllers and the memory model.

## Interface
- `BADDR_W`, default 28: block address width (`DMEM_BLOCK_ADDR_SIZE`).
- `BLOCK_W`, default 128: block data width (`DBLOCK_SIZE_BITS`).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `icRen` in 1: icache block read request, level, held until `icReadReady`.
- `icBlockAddr` in `BADDR_W`: icache block address.
- `icReadReady` out 1: icache read data valid.
- `icDout` out `BLOCK_W`: icache read data.
- `dcRen`, `dcWen` in 1: dcache block read/writeback request, level.
- `dcBlockAddr` in `BADDR_W`: dcache block address.
- `dcDin` in `BLOCK_W`: dcache writeback data.
- `dcReadReady`, `dcWriteDone` out 1: dcache completion.
- `dcDout` out `BLOCK_W`: dcache read data.
- `memRen`, `memWen` out 1: memory strobes, level.
- `memBlockAddr` out `BADDR_W`, `memDin` out `BLOCK_W`: to memory.
- `memReadReady`, `memWriteDone` in 1: memory completion pulses.
- `memDout` in `BLOCK_W`: memory read data.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE: if any request is pending, choose a winner, latch its address, data and operation, and go to GRANT_I or GRANT_D. Otherwise stay in IDLE.
- Default arbitration: dcache has fixed priority over icache.
- dcache operation select: if `dcRen` and `dcWen` are both high, the request is a write (`dcWen` wins).
- GRANT_I: drive `memRen=1` and `memBlockAddr` from the latched address.
- GRANT_D: drive `memRen` or `memWen` from the latched operation.
- Completion: `memReadReady` or `memWriteDone` is forwarded combinationally to the granted requester only. `icDout` and `dcDout` both carry `memDout`, but each ready signal is asserted only for the owner.
- On completion, go to RELEASE. Completion of the wrong type (for example `memWriteDone` during a read grant) is ignored.
- Abort: if the granted requester drops all of its request lines before completion, return to IDLE on the next edge with no completion forwarded.
- RELEASE: strobes low for 1 cycle so the requester can deassert or re-issue. Then IDLE.
- Non-granted requester: sees its ready outputs held at 0 and simply waits; its request stays pending.

## Timing
- Reset values: all outputs 0, state IDLE, latched address/data/operation cleared. Reset asserted mid-grant drops the strobes immediately (asynchronously).
- Grant latency: request high in IDLE at edge N, strobe high from edge N+1.
- Completion: ready/done to the requester in the same cycle as the memory pulse.
- Back-to-back access: memory strobes are low for at least 1 cycle (RELEASE) between consecutive grants.
- Minimum turnaround is 3 cycles plus memory latency.
- Latched address and data remain stable for the whole grant, even if requester inputs change.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: a 1-bit last-winner register (reset value: icache) gives priority to the requester that did not win last, when both request in IDLE. A lone requester always wins.
- Not defined: fixed dcache priority. The last-winner register is absent.

## Structure
- Shared package/include holds:
  - the state encoding (`ARB_IDLE`, `ARB_GRANT_I`, `ARB_GRANT_D`, `ARB_RELEASE`);
  - the requester ID constants (`ARB_ID_I=0`, `ARB_ID_D=1`);
  - the existing `DMEM_BLOCK_ADDR_SIZE` and `DBLOCK_SIZE_BITS` constants.
- One natural sub-module: `arb_pick`, a combinational winner select. Its inputs are the two request bits and the priority bit; its output is the winner ID.

## Test plan
- Lone icache read of addr `0x0000010`, memory ready after 4 cycles:
  - `memRen` high from cycle 1 with `memBlockAddr=0x0000010`;
  - `icReadReady` pulses with `icDout=memDout`;
  - `dcReadReady` stays 0.
- dcache writeback and icache read raised in the same cycle, macro off:
  - dcache granted first (`memWen=1`, `memDin=dcDin`);
  - after `memWriteDone`, 1 RELEASE cycle, then icache granted.
- Macro on, both requesting continuously for 4 grants: grant order D, I, D, I (dcache first, since the last-winner register resets to icache).
- `dcRen=dcWen=1`: treated as a write, so `memWen=1` and `memRen=0`.
- dcache drops `dcRen` at grant cycle 2 with no memory response: FSM returns to IDLE, strobes go to 0 the next cycle, no ready is forwarded.
- Reset pulsed low during GRANT_D with `memWen=1`:
  - `memWen` drops immediately;
  - after release, IDLE with all outputs 0.
